// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared half-precision field widths, constants, flag indices and FSM states
package fpu_pkg;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SEM_W  = 1 + EXP_W + FRAC_W;

    localparam logic [SEM_W-1:0] CANON_NAN = 16'h7E00;

    localparam int FLAG_W    = 3;
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_INV  = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;
endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational NaN/infinity/zero classification of one half-precision value
module fp16_classify
    import fpu_pkg::*;
(
    input  logic [SEM_W-1:0] sem,
    output logic             is_nan,
    output logic             is_inf,
    output logic             is_zero
);
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f   = sem[SEM_W-2 -: EXP_W];
    assign frac_f  = sem[FRAC_W-1:0];
    assign is_nan  = (&exp_f) && (frac_f != '0);
    assign is_inf  = (&exp_f) && (frac_f == '0);
    assign is_zero = (sem[SEM_W-2:0] == '0);
endmodule

// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - operand FIFO and issue FSM feeding an external combinational FP16 adder
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEM_W-1:0]  Asem_in,
    input  logic [SEM_W-1:0]  Bsem_in,
    input  logic              op_sub,
    output logic [SEM_W-1:0]  fpu_Asem,
    output logic [SEM_W-1:0]  fpu_Bsem,
    input  logic [SEM_W-1:0]  fpu_Rsem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEM_W-1:0]  Rsem_out,
    output logic [FLAG_W-1:0] flags,
    output logic [15:0]       res_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [2*SEM_W-1:0] mem [DEPTH];
    logic [2*SEM_W-1:0] head;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               empty, push, pop, sample;

    state_t             state_q, state_d;
    logic [CW-1:0]      settle_q;
    logic [SEM_W-1:0]   a_q, b_q, rsem_q;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic [SEM_W-1:0]   res_d;

    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic invalid, both_finite, unused_zero;

    assign empty    = (count == '0);
    assign in_ready = (count != (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // Subtraction is folded into the stored B sign so the FPU only ever adds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {Asem_in, Bsem_in[SEM_W-1] ^ op_sub, Bsem_in[SEM_W-2:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (settle_q == '0) begin
                    sample  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    pop     = !empty;
                    state_d = empty ? IDLE : WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fp16_classify u_cls_a (.sem(a_q), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
    fp16_classify u_cls_b (.sem(b_q), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

    // Operand zeroness does not affect the result; the zero flag looks at the result itself.
    assign unused_zero = a_zero | b_zero;
    assign invalid     = a_nan || b_nan || (a_inf && b_inf && (a_q[SEM_W-1] ^ b_q[SEM_W-1]));
    assign both_finite = !(a_nan || a_inf || b_nan || b_inf);
    assign res_d       = invalid ? CANON_NAN : fpu_Rsem;

    always_comb begin
        flags_d            = '0;
        flags_d[FLAG_INV]  = invalid;
        flags_d[FLAG_OVF]  = both_finite && (&fpu_Rsem[SEM_W-2 -: EXP_W]);
        flags_d[FLAG_ZERO] = (res_d[SEM_W-2:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsem_q    <= '0;
            flags_q   <= '0;
            res_count <= '0;
        end else begin
            if (pop) begin
                {a_q, b_q} <= head;
                settle_q   <= CW'(SETTLE - 1);
            end else if (state_q == WAIT && settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end
            if (sample) begin
                rsem_q  <= res_d;
                flags_q <= flags_d;
            end
            if (out_valid && out_ready) res_count <= res_count + 1'b1;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign fpu_Asem  = a_q;
    assign fpu_Bsem  = b_q;
    assign Rsem_out  = rsem_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - directed self-checking bench for fpu_issue with a stub FP16 adder
module tb_fpu_issue;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] Asem_in = '0;
    logic [15:0] Bsem_in = '0;
    logic        in_ready, out_valid;
    logic [15:0] fpu_Asem, fpu_Bsem, fpu_Rsem, Rsem_out, res_count;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in adder: exact sums for the directed vectors, XOR elsewhere.
    function automatic logic [15:0] fpu_stub(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {16'h4000, 16'h4000}: return 16'h4400;
            {16'h4000, 16'hC000}: return 16'h0000;
            {16'h7BFF, 16'h7BFF}: return 16'h7C00;
            default:              return a ^ b;
        endcase
    endfunction

    assign fpu_Rsem = fpu_stub(fpu_Asem, fpu_Bsem);

    fpu_issue #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Asem_in(Asem_in), .Bsem_in(Bsem_in), .op_sub(op_sub),
        .fpu_Asem(fpu_Asem), .fpu_Bsem(fpu_Bsem), .fpu_Rsem(fpu_Rsem),
        .out_valid(out_valid), .out_ready(out_ready),
        .Rsem_out(Rsem_out), .flags(flags), .res_count(res_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rsem"},      32'(Rsem_out),  32'h0);
        check({tag, "_flags"},     32'(flags),     32'h0);
        check({tag, "_res_count"}, 32'(res_count), 32'h0);
        check({tag, "_fpu_a"},     32'(fpu_Asem),  32'h0);
        check({tag, "_fpu_b"},     32'(fpu_Bsem),  32'h0);
    endtask

    task automatic issue_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic [15:0] exp_r, input logic [2:0] exp_fl,
                             input logic [15:0] exp_b);
        int n;
        Asem_in   = a;
        Bsem_in   = b;
        op_sub    = sub;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        op_sub   = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n),        32'(SETTLE + 1));
        check({tag, "_rsem"},    32'(Rsem_out), 32'(exp_r));
        check({tag, "_flags"},   32'(flags),    32'(exp_fl));
        check({tag, "_fpu_b"},   32'(fpu_Bsem), 32'(exp_b));
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] exp_q[$];

    initial begin
        int acc, k, cyc, last, seen;

        rst_n = 1'b0;
        repeat (2) tick();
        check_reset("rst");
        rst_n = 1'b1;

        issue_one("add",     16'h4000, 16'h4000, 1'b0, 16'h4400, 3'b000, 16'h4000);
        issue_one("sub",     16'h4000, 16'h4000, 1'b1, 16'h0000, 3'b001, 16'hC000);
        issue_one("nan",     16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 3'b100, 16'h3C00);
        issue_one("inf_inf", 16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100, 16'hFC00);
        issue_one("ovf",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010, 16'h7BFF);
        check("res_count_5", 32'(res_count), 32'd5);

        // Backpressure: one pair parks in the operand register, DEPTH more fill the FIFO.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            Asem_in = 16'h3000 + 16'(i);
            Bsem_in = 16'(16'h0011 * (i + 1));
            if (in_ready) begin
                exp_q.push_back(Asem_in ^ Bsem_in);
                acc++;
            end
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc),      32'(DEPTH + 1));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_valid",    32'(out_valid), 32'd1);
        check("bp_first",    32'(Rsem_out), 32'(exp_q[0]));
        repeat (3) tick();
        check("bp_stable",   32'(Rsem_out), 32'(exp_q[0]));
        check("bp_valid2",   32'(out_valid), 32'd1);

        out_ready = 1'b1;
        k = 0;
        cyc = 0;
        last = 0;
        while (k < acc && cyc < 100) begin
            if (out_valid) begin
                check($sformatf("bp_res%0d", k), 32'(Rsem_out), 32'(exp_q[k]));
                if (k > 0) check($sformatf("bp_gap%0d", k), 32'(cyc - last), 32'(SETTLE + 1));
                last = cyc;
                k++;
            end
            tick();
            cyc++;
        end
        check("bp_count",     32'(k),         32'(acc));
        check("bp_res_count", 32'(res_count), 32'(DEPTH + 1));
        repeat (3) tick();
        check("bp_idle", 32'(out_valid), 32'd0);

        // Reset during WAIT with two pairs still queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Asem_in = 16'h2000 + 16'(i);
            Bsem_in = 16'h0101;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("mr_hold", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("mr_wait_op", 32'(fpu_Asem),  32'h2001);
        check("mr_wait_nv", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset("mr");
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mr_no_output", 32'(seen),      32'd0);
        check("mr_res_count", 32'(res_count), 32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter DEPTH, default 4, sets the input operand FIFO depth in entries (power of two, minimum 2).
REQ-002 Parameter SETTLE, default 1, sets the wait in cycles between driving fpu_Asem/fpu_Bsem and sampling fpu_Rsem (minimum 1).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  FIFO can accept a pair.
REQ-007 Asem_in  input  16  operand A, half precision {sign, exp[4:0], frac[9:0]}.
REQ-008 Bsem_in  input  16  operand B, same format.
REQ-009 op_sub  input  1  1 = compute A-B by inverting the B sign before issue.
REQ-010 fpu_Asem  output  16  operand A driven to the combinational FPU.
REQ-011 fpu_Bsem  output  16  operand B driven to the FPU, sign already adjusted.
REQ-012 fpu_Rsem  input  16  FPU sum.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 Rsem_out  output  16  result.
REQ-016 flags  output  3  {invalid, overflow, zero} for the current result.
REQ-017 res_count  output  16  count of results accepted downstream; wraps from 0xFFFF to 0.

Function
REQ-018 An input transfer shall occur when in_valid and in_ready are both high on a rising edge.
REQ-019 The FIFO shall store {Asem_in, Bsem_in^(op_sub<<15)}.
REQ-020 in_ready shall be low only when the FIFO holds DEPTH entries.
REQ-021 A push and a pop in the same cycle shall both take effect, including when the FIFO is full.
REQ-022 FSM state IDLE: while the FIFO is non-empty, pop the head into the operand register, go to WAIT, and load the settle counter with SETTLE-1.
REQ-023 FSM state WAIT: decrement the settle counter; at 0, sample fpu_Rsem, compute flags, and go to HOLD.
REQ-024 FSM state HOLD: out_valid shall be high; on out_ready, increment res_count, then go to WAIT if the FIFO is non-empty (popping the head the same cycle), else to IDLE.
REQ-025 Rsem_out and flags shall hold stable while out_valid is high and out_ready is low.
REQ-026 fpu_Asem/fpu_Bsem shall be driven from the operand register, stable from issue through sampling; they are 0 in IDLE after reset.
REQ-027 If either operand is NaN (exp=31, frac!=0), Rsem_out shall be 0x7E00 with invalid=1; fpu_Rsem is ignored.
REQ-028 If both operands are infinite with opposite signs, Rsem_out shall be 0x7E00 with invalid=1.
REQ-029 If both operands are finite and fpu_Rsem has exp=31, overflow shall be 1 and Rsem_out shall equal fpu_Rsem.
REQ-030 zero shall be 1 when Rsem_out[14:0]==0.
REQ-031 Latency from input transfer to out_valid shall be SETTLE+1 cycles when the FSM is in IDLE and the FIFO is empty.
REQ-032 Sustained throughput shall be one result per SETTLE+1 cycles when out_ready is held high.

Reset
REQ-033 When rst_n is low: FIFO empty, FSM IDLE, in_ready=1, out_valid=0, Rsem_out=0, flags=0, res_count=0, fpu_Asem=fpu_Bsem=0.
REQ-034 Reset asserted mid-operation shall discard queued and in-flight operations with no partial output.
REQ-035 The first transfer shall be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-036 A shared package fpu_pkg shall hold the field widths (EXP_W=5, FRAC_W=10), the canonical NaN constant 0x7E00, the flag bit indices, and the FSM state enum.
REQ-037 One sub-module, fp16_classify, shall be purely combinational and output is_nan, is_inf and is_zero; it is instantiated twice, once per operand.
REQ-038 The FPU is not instantiated in this module; the bench connects it through the fpu_* ports.

Verification
REQ-039 Issue 0x4000+0x4000, with out_ready=1 and the FPU connected -> Rsem_out=0x4400, flags=000, out_valid SETTLE+1 cycles after the transfer.
REQ-040 Issue 0x4000 with op_sub=1 and B=0x4000 -> fpu_Bsem=0xC000, Rsem_out=0x0000, zero=1.
REQ-041 Issue A=0x7C01, B=0x3C00 -> Rsem_out=0x7E00, invalid=1; issue 0x7C00+0xFC00 -> 0x7E00, invalid=1.
REQ-042 Issue 0x7BFF+0x7BFF -> overflow=1, Rsem_out=0x7C00.
REQ-043 Hold out_ready=0 and push DEPTH+2 pairs -> in_ready falls after DEPTH+1 accepted, Rsem_out stable; release -> all results in order, res_count=DEPTH+1.
REQ-044 Assert rst_n low during WAIT with 2 pairs queued -> all outputs at reset values, no result emitted after release.
